// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-field helpers for the
// direct-mapped instruction cache.
package icache_pkg;

  // Cache controller states.
  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WAIT,
    RESPOND
  } state_e;

  // Default geometry; the top-level parameters start from these values.
  localparam int NUM_LINES_DEF      = 16;
  localparam int WORDS_PER_LINE_DEF = 4;

  // Field boundaries for the default geometry.
  localparam int OB    = 2 + $clog2(WORDS_PER_LINE_DEF);
  localparam int IB    = $clog2(NUM_LINES_DEF);
  localparam int TAG_W = 32 - OB - IB;

  // Word offset within a line: bits [ob-1:2].
  function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int ob);
    return (addr >> 2) & ((32'd1 << (ob - 2)) - 32'd1);
  endfunction

  // Line index: bits [ob+ib-1:ob].
  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int ob,
                                             input int ib);
    return (addr >> ob) & ((32'd1 << ib) - 32'd1);
  endfunction

  // Tag: everything above the index field.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int tag_lsb);
    return addr >> tag_lsb;
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Bundle of fetch-side, memory-side, flush and statistics signals of the
// instruction cache. The slave view is the cache itself; the master view is
// whatever surrounds it (fetch stage plus backing memory).
interface icache_dm_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic        rsp_err;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, rsp_valid, rsp_instr, rsp_err, mem_req_valid, mem_req_addr,
           hit_cnt, miss_cnt
  );

  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_err, mem_req_valid, mem_req_addr,
           hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_tag_store.sv
// Valid bits and tags for every cache line, with a combinational hit check
// and a whole-cache invalidate.
module icache_tag_store
  import icache_pkg::*;
#(
  parameter int NUM_LINES = NUM_LINES_DEF,
  parameter int IB_W      = IB,
  parameter int TAG_W_P   = TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_all,
  input  logic [IB_W-1:0]    lookup_idx,
  input  logic [TAG_W_P-1:0] lookup_tag,
  output logic               hit,
  input  logic               wr_en,
  input  logic [IB_W-1:0]    wr_idx,
  input  logic [TAG_W_P-1:0] wr_tag
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W_P-1:0]   tag_q [NUM_LINES];
  logic [TAG_W_P-1:0]   tag_d [NUM_LINES];

  // Lookup reads the registered state, so a clear in this cycle does not
  // affect the hit seen in this cycle.
  assign hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

  // Next valid/tag state: invalidate everything, then apply a line fill.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (clear_all) begin
      valid_d = '0;
    end
    if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
    end
  end

  // Valid bits are the only state that needs a defined reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tags are meaningless while their valid bit is clear, so they are not reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped RV32I instruction cache: one-cycle hits, whole-line refill
// with a single outstanding memory read, fence.i flush and hit/miss counters.
module icache_dm
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = NUM_LINES_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  icache_dm_if.slave  bus
);

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int OB_L    = 2 + OFF_W;
  localparam int IB_L    = $clog2(NUM_LINES);
  localparam int TAG_W_L = 32 - OB_L - IB_L;
  localparam int DEPTH   = NUM_LINES * WORDS_PER_LINE;
  localparam int DA_W    = IB_L + OFF_W;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              flush_pend_q, flush_pend_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];

  logic [IB_L-1:0]    req_idx;
  logic [TAG_W_L-1:0] req_tag;
  logic [OFF_W-1:0]   req_off;
  logic               misaligned;
  logic               hit;
  logic [DA_W-1:0]    rd_addr;
  logic [DA_W-1:0]    wr_addr;

  logic               tag_clear;
  logic               tag_wr;
  logic               data_wr;
  logic               req_ready_c;
  logic               rsp_valid_c;
  logic               rsp_err_c;
  logic [31:0]        rsp_instr_c;
  logic               mem_req_valid_c;
  logic [31:0]        mem_req_addr_c;

  assign req_idx    = IB_L'(addr_index(addr_q, OB_L, IB_L));
  assign req_tag    = TAG_W_L'(addr_tag(addr_q, OB_L + IB_L));
  assign req_off    = OFF_W'(addr_offset(addr_q, OB_L));
  assign misaligned = (addr_q[1:0] != 2'b00);
  assign rd_addr    = {req_idx, req_off};
  assign wr_addr    = {req_idx, beat_q};

  icache_tag_store #(
    .NUM_LINES (NUM_LINES),
    .IB_W      (IB_L),
    .TAG_W_P   (TAG_W_L)
  ) u_tag_store (
    .clk        (clk),
    .rst        (rst),
    .clear_all  (tag_clear),
    .lookup_idx (req_idx),
    .lookup_tag (req_tag),
    .hit        (hit),
    .wr_en      (tag_wr),
    .wr_idx     (req_idx),
    .wr_tag     (req_tag)
  );

  // Controller: next state, counters, response and memory-request outputs.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    beat_d          = beat_q;
    flush_pend_d    = flush_pend_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    tag_clear       = 1'b0;
    tag_wr          = 1'b0;
    data_wr         = 1'b0;
    req_ready_c     = 1'b0;
    rsp_valid_c     = 1'b0;
    rsp_err_c       = 1'b0;
    rsp_instr_c     = 32'd0;
    mem_req_valid_c = 1'b0;
    mem_req_addr_c  = 32'd0;

    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        tag_clear   = bus.flush;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        tag_clear = bus.flush;
        if (misaligned || hit) begin
          rsp_valid_c = 1'b1;
          req_ready_c = 1'b1;
          if (misaligned) begin
            rsp_err_c = 1'b1;
          end else begin
            rsp_instr_c = data_q[rd_addr];
            hit_cnt_d   = hit_cnt_q + 32'd1;
          end
          if (bus.req_valid) begin
            addr_d  = bus.req_addr;
            state_d = LOOKUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          beat_d     = '0;
          state_d    = REFILL;
        end
      end

      REFILL: begin
        flush_pend_d    = flush_pend_q | bus.flush;
        mem_req_valid_c = 1'b1;
        mem_req_addr_c  = {addr_q[31:OB_L], beat_q, 2'b00};
        if (bus.mem_req_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        flush_pend_d = flush_pend_q | bus.flush;
        if (bus.mem_rsp_valid) begin
          data_wr = 1'b1;
          if (beat_q == OFF_W'(WORDS_PER_LINE - 1)) begin
            tag_wr  = 1'b1;
            state_d = RESPOND;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = REFILL;
          end
        end
      end

      RESPOND: begin
        rsp_valid_c  = 1'b1;
        rsp_instr_c  = data_q[rd_addr];
        tag_clear    = flush_pend_q | bus.flush;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Returning data lands in the line slot selected by the current beat.
  always_comb begin
    data_d = data_q;
    if (data_wr) begin
      data_d[wr_addr] = bus.mem_rsp_data;
    end
  end

  // Control state and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Instruction words; validity is tracked by the tag store, so no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign bus.req_ready     = req_ready_c & ~rst;
  assign bus.rsp_valid     = rsp_valid_c;
  assign bus.rsp_err       = rsp_err_c;
  assign bus.rsp_instr     = rsp_instr_c;
  assign bus.mem_req_valid = mem_req_valid_c;
  assign bus.mem_req_addr  = mem_req_addr_c;
  assign bus.hit_cnt       = hit_cnt_q;
  assign bus.miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a zero-wait memory model and scoreboards
// for fetch responses and memory read addresses.
module tb_icache_dm;
  import icache_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          cyc;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   waited;

  rsp_exp_t    rsp_q[$];
  logic [31:0] mem_q[$];

  icache_dm_if bus();

  icache_dm #(
    .NUM_LINES      (16),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Zero-wait memory: data arrives one cycle after an accepted request.
  always @(posedge clk) begin
    bus.mem_rsp_valid <= bus.mem_req_valid & bus.mem_req_ready;
    bus.mem_rsp_data  <= bus.mem_req_addr ^ 32'hA5A5_0000;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response scoreboard.
  always @(negedge clk) begin
    rsp_exp_t e;
    if (bus.rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        checkOutput("rsp_unexpected", {31'd0, bus.rsp_valid}, 32'd0);
      end else begin
        e = rsp_q.pop_front();
        checkOutput("rsp_instr", bus.rsp_instr, e.instr);
        checkOutput("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        checkOutput("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Memory request scoreboard.
  always @(negedge clk) begin
    logic [31:0] a;
    if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) begin
      if (mem_q.size() == 0) begin
        checkOutput("mem_unexpected", bus.mem_req_addr, 32'hFFFF_FFFF);
      end else begin
        a = mem_q.pop_front();
        checkOutput("mem_req_addr", bus.mem_req_addr, a);
      end
    end
  end

  // Drives one request from a negedge and records what it should produce.
  task automatic applyStimulus(input logic [31:0] addr, input int lat, input int beats,
                               output int wait_cycles);
    logic [31:0] base;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    wait_cycles   = 0;
    while (bus.req_ready !== 1'b1 && wait_cycles < 200) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (bus.req_ready !== 1'b1) begin
      checkOutput("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
    end else begin
      rsp_q.push_back('{instr: (addr[1:0] != 2'b00) ? 32'd0 : (addr ^ 32'hA5A5_0000),
                        err:   (addr[1:0] != 2'b00),
                        cyc:   cyc + lat});
      base = {addr[31:OB], {OB{1'b0}}};
      for (int b = 0; b < beats; b++) mem_q.push_back(base + 32'(4 * b));
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((rsp_q.size() != 0 || mem_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0 || mem_q.size() != 0)
      checkOutput("drain_timeout", 32'(rsp_q.size() + mem_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid     = 1'b0;
    bus.req_addr      = 32'd0;
    bus.flush         = 1'b0;
    bus.mem_req_ready = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_mem_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    checkOutput("rst_rsp_instr", bus.rsp_instr, 32'd0);
    checkOutput("rst_mem_addr", bus.mem_req_addr, 32'd0);
    checkOutput("rst_hit_cnt", bus.hit_cnt, 32'd0);
    checkOutput("rst_miss_cnt", bus.miss_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Cold miss.
    applyStimulus(32'h0000_0104, 10, 4, waited);
    waitDrain();
    checkOutput("s1_miss_cnt", bus.miss_cnt, 32'd1);
    checkOutput("s1_hit_cnt", bus.hit_cnt, 32'd0);

    // Streaming hits.
    applyStimulus(32'h0000_0100, 1, 0, waited);
    applyStimulus(32'h0000_0104, 1, 0, waited);
    checkOutput("s2_ready_held", 32'(waited), 32'd0);
    applyStimulus(32'h0000_0108, 1, 0, waited);
    checkOutput("s2_ready_held", 32'(waited), 32'd0);
    applyStimulus(32'h0000_010C, 1, 0, waited);
    checkOutput("s2_ready_held", 32'(waited), 32'd0);
    waitDrain();
    checkOutput("s2_hit_cnt", bus.hit_cnt, 32'd4);

    // Conflict misses on index 0.
    applyStimulus(32'h0000_0204, 10, 4, waited);
    waitDrain();
    applyStimulus(32'h0000_0104, 10, 4, waited);
    waitDrain();
    checkOutput("s3_miss_cnt", bus.miss_cnt, 32'd3);

    // Misaligned PC.
    applyStimulus(32'h0000_0102, 1, 0, waited);
    waitDrain();
    checkOutput("s4_hit_cnt", bus.hit_cnt, 32'd4);
    checkOutput("s4_miss_cnt", bus.miss_cnt, 32'd3);

    // Flush during refill is deferred; response still delivered.
    applyStimulus(32'h0000_0300, 10, 4, waited);
    repeat (2) @(negedge clk);
    checkOutput("s5_in_wait", {31'd0, bus.mem_req_valid}, 32'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    waitDrain();
    applyStimulus(32'h0000_0300, 10, 4, waited);
    waitDrain();
    checkOutput("s5_miss_cnt", bus.miss_cnt, 32'd5);
    applyStimulus(32'h0000_0300, 1, 0, waited);
    waitDrain();
    checkOutput("s5_hit_cnt", bus.hit_cnt, 32'd5);

    // Flush while idle.
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    applyStimulus(32'h0000_0300, 10, 4, waited);
    waitDrain();
    checkOutput("s5_idle_flush_miss", bus.miss_cnt, 32'd6);

    // Flush during a hit lookup: the lookup still hits, the next one misses.
    applyStimulus(32'h0000_0300, 1, 0, waited);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    waitDrain();
    checkOutput("s5_lookup_flush_hit", bus.hit_cnt, 32'd6);
    applyStimulus(32'h0000_0300, 10, 4, waited);
    waitDrain();
    checkOutput("s5_lookup_flush_miss", bus.miss_cnt, 32'd7);

    // Reset during the second refill beat.
    applyStimulus(32'h0000_0540, 10, 2, waited);
    repeat (3) @(negedge clk);
    checkOutput("s6_beat1_addr", bus.mem_req_addr, 32'h0000_0544);
    rst = 1'b1;
    @(negedge clk);
    rsp_q.delete();
    checkOutput("s6_mem_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    checkOutput("s6_req_ready", {31'd0, bus.req_ready}, 32'd0);
    checkOutput("s6_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("s6_mem_addr", bus.mem_req_addr, 32'd0);
    checkOutput("s6_hit_cnt", bus.hit_cnt, 32'd0);
    checkOutput("s6_miss_cnt", bus.miss_cnt, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("s6_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("s6_idle_mem", {31'd0, bus.mem_req_valid}, 32'd0);
    applyStimulus(32'h0000_0540, 10, 4, waited);
    waitDrain();
    checkOutput("s6_miss_cnt_after", bus.miss_cnt, 32'd1);
    checkOutput("s6_hit_cnt_after", bus.hit_cnt, 32'd0);

    checkOutput("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    checkOutput("mem_q_empty", 32'(mem_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, parametrised RV32I instruction cache between the fetch stage and a word-wide backing instruction memory. It returns 32-bit little-endian instruction words on hits one cycle after acceptance, refills whole lines on a miss through a one-beat-outstanding memory handshake, supports a full invalidate for `fence.i`, and counts hits and misses.

## Interface
- `NUM_LINES`, 16: number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: fetch request valid.
- `req_addr` in 32: byte PC.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `rsp_valid` out 1: one-cycle response pulse. No backpressure.
- `rsp_instr` out 32: instruction word.
- `rsp_err` out 1: misaligned PC (`req_addr[1:0]!=0`); `rsp_instr`=0.
- `flush` in 1: invalidate all lines.
- `mem_req_valid` out 1: memory word read request.
- `mem_req_addr` out 32: word-aligned byte address.
- `mem_req_ready` in 1: memory accepts request.
- `mem_rsp_valid` in 1: read data valid.
- `mem_rsp_data` in 32: read data, little-endian word.
- `hit_cnt` out 32: hits since reset; wraps.
- `miss_cnt` out 32: misses since reset; wraps.

## Operation
- Address split: offset `[OB-1:2]` with OB = 2+log2(WORDS_PER_LINE); index `[OB+IB-1:OB]` with IB = log2(NUM_LINES); tag is the remaining upper bits.
- Storage: valid bit and tag per line, plus a data array. Valid bits clear on reset. Tag and data contents are undefined after reset.
- States:
  - IDLE: `req_ready`=1. On acceptance, register the address and go to LOOKUP.
  - LOOKUP: hit is `valid[idx] && tag==tag[idx]`.
    - Hit: `rsp_valid`=1, `hit_cnt`++, `req_ready`=1, so back-to-back hits stream one per cycle. With a new request go to LOOKUP, otherwise IDLE.
    - Miss: `req_ready`=0, `miss_cnt`++, beat=0, go to REFILL.
    - Misaligned: `rsp_valid`=1, `rsp_err`=1, no counter change, no refill, behave as hit for flow.
  - REFILL: `mem_req_valid`=1 with `mem_req_addr` = line base + 4·beat until `mem_req_ready`, then go to WAIT.
  - WAIT: on `mem_rsp_valid`, write the data word. If it is the last beat, write the tag, set valid, and go to RESPOND. Otherwise beat++ and go to REFILL.
  - RESPOND: `rsp_valid`=1 with the requested word taken from the data array (independent of the valid bit). `req_ready`=0. Go to IDLE.
- Flush:
  - In IDLE or LOOKUP, all valid bits clear at the next edge. A LOOKUP in that same cycle still uses the pre-flush valid bits.
  - In REFILL, WAIT or RESPOND, flush is latched and applied on RESPOND→IDLE, which also clears the just-refilled line.
- `mem_rsp_valid` outside WAIT is ignored.
- Counters increment by 1 and wrap 0xFFFF_FFFF→0.

## Timing
- Reset values: `req_ready`=0 in the reset cycle, then 1 in IDLE. `rsp_valid`, `rsp_err`, `mem_req_valid`, `hit_cnt`, `miss_cnt` are 0. `rsp_instr` and `mem_req_addr` are 0. State is IDLE and the pending flush is cleared.
- Hit latency: accept at cycle N → `rsp_valid` at N+1.
- Miss latency with a zero-wait memory (ready=1 and data one cycle after request): accept N, LOOKUP N+1, then 2 cycles per beat, RESPOND at N+2+2·WORDS_PER_LINE.
- `mem_req_valid` holds with a stable address until `mem_req_ready`. Only one request is outstanding at a time.
- `rst` during a refill: state returns to IDLE, `mem_req_valid` drops at the next edge, valid bits clear, and any late `mem_rsp_valid` is ignored.

## Structure
- Package `icache_pkg` holds:
  - the state enum (IDLE, LOOKUP, REFILL, WAIT, RESPOND);
  - the `$clog2`-based constants OB, IB and TAG_W;
  - the field-extraction functions.
- Sub-module `icache_tag_store`: valid and tag arrays, synchronous clear on reset and flush, combinational hit compare.
- The data array and FSM live in the top level.

## Test plan
All scenarios use NUM_LINES=16, WORDS_PER_LINE=4, a zero-wait memory model, and memory word = address ^ 0xA5A5_0000.
1. Cold miss at 0x0000_0104 → memory requests 0x100, 0x104, 0x108, 0x10C. Then `rsp_instr`=0xA5A5_0104, `miss_cnt`=1, RESPOND 10 cycles after acceptance.
2. Back-to-back requests 0x100, 0x104, 0x108, 0x10C after scenario 1 → four consecutive `rsp_valid` cycles, `hit_cnt`=4, `req_ready` held high.
3. Conflict: 0x0000_0204 after 0x104 (same index 0, different tag) → miss and refill. Re-request 0x104 → miss again; `miss_cnt`=3.
4. Misaligned request 0x0000_0102 → `rsp_err`=1 one cycle later, no `mem_req_valid`, counters unchanged.
5. Flush asserted during the WAIT of a refill for 0x300 → the response is still delivered. A following 0x300 request misses.
6. `rst` asserted during the second refill beat → next cycle `mem_req_valid`=0 and outputs at reset values. A late `mem_rsp_valid` is ignored, and a subsequent request to the same line misses.
